// File: rtl/tri_pkg.sv
// Shared definitions for the triangular step decoder: default sizes,
// FSM state encoding and the closed-form value of the forward recurrence.
package tri_pkg;

    localparam int W_DEF     = 19;
    localparam int LIMIT_DEF = 200;
    localparam int NW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // x(k) = 1 + k(k-1)/2, the accumulator value after k steps.
    function automatic longint tri_x(input longint k);
        return 64'sd1 + (k * (k - 64'sd1)) / 64'sd2;
    endfunction

endpackage

// File: rtl/tri_step_decoder_if.sv
// Request/response bundle of the triangular step decoder.
// The master issues targets and consumes results; the slave is the decoder.
interface tri_step_decoder_if #(
    parameter int W  = 19,
    parameter int NW = 8
) ();

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_t;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] out_n;
    logic [W-1:0]  out_r;
    logic          out_sat;
    logic          out_uflow;

    modport master (
        output in_valid, in_t, out_ready,
        input  in_ready, out_valid, out_n, out_r, out_sat, out_uflow
    );

    modport slave (
        input  in_valid, in_t, out_ready,
        output in_ready, out_valid, out_n, out_r, out_sat, out_uflow
    );

endinterface

// File: rtl/tri_step_gen.sv
// Recurrence registers of the triangular accumulator: x<-x+y, y<-y+1.
// load restarts the sequence at x=1, y=0; step advances it by one.
module tri_step_gen #(
    parameter int W  = 19,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    output logic [W-1:0]  x,
    output logic [NW-1:0] y,
    output logic [W:0]    xy
);

    // One bit wider than x so the bound comparison downstream never wraps.
    assign xy = {1'b0, x} + (W+1)'(y);

    // Restart or advance the recurrence; load has priority over step.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of the others, independent of order.
        if (rst) begin
            x <= W'(1);
            y <= '0;
        end else if (load) begin
            x <= W'(1);
            y <= '0;
        end else if (step) begin
            x <= xy[W-1:0];
            y <= y + NW'(1);
        end
    end

endmodule

// File: rtl/tri_step_decoder.sv
// Inverse of the triangular step accumulator: for a target t, finds the
// largest n in [0, LIMIT] with x(n) <= t and the residue t - x(n), by
// re-running the recurrence one step per cycle behind a valid/ready pair.
module tri_step_decoder
    import tri_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LIMIT = LIMIT_DEF,
    parameter int NW    = NW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    tri_step_decoder_if.slave  bus
);

    // The largest reachable x and the step count must both fit their fields.
    if (tri_x(LIMIT) >= (64'sd1 <<< W)) begin : g_w_check
        $error("tri_step_decoder: x(LIMIT) does not fit in W bits");
    end
    if ((64'sd1 <<< NW) <= LIMIT) begin : g_nw_check
        $error("tri_step_decoder: NW too narrow for LIMIT");
    end

    state_t        state;
    logic [W-1:0]  t;
    logic [W-1:0]  x;
    logic [NW-1:0] y;
    logic [W:0]    xy;
    logic          load;
    logic          step;
    logic          under;
    logic          at_limit;
    logic          fits;

    assign under    = (x > t);
    assign at_limit = (y == NW'(LIMIT));
    assign fits     = (xy <= {1'b0, t});
    assign load     = (state == IDLE) && bus.in_valid;
    assign step     = (state == RUN) && !under && !at_limit && fits;

    tri_step_gen #(
        .W  (W),
        .NW (NW)
    ) u_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .x    (x),
        .y    (y),
        .xy   (xy)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            t             <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_n     <= '0;
            bus.out_r     <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_uflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        t            <= bus.in_t;
                        bus.in_ready <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (under) begin
                        // Only t == 0 lands here, on the first RUN cycle.
                        bus.out_n     <= '0;
                        bus.out_r     <= '0;
                        bus.out_sat   <= 1'b0;
                        bus.out_uflow <= 1'b1;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (at_limit) begin
                        bus.out_n     <= y;
                        bus.out_r     <= t - x;
                        bus.out_sat   <= 1'b1;
                        bus.out_uflow <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (!fits) begin
                        bus.out_n     <= y;
                        bus.out_r     <= t - x;
                        bus.out_sat   <= 1'b0;
                        bus.out_uflow <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // Result held until consumed; no accept in this same cycle.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
